// File: rtl/matmul_sequencer.sv
// Round sequencer for the matrix-multiply result path: loads a 2x2 operand set,
// steps the PE-array, 3x3 and 2x2 engines and the display, with a per-phase hang timeout.
module matmul_sequencer #(
  parameter int unsigned TIMEOUT = 64
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        start_i,
  input  logic        din_valid_i,
  input  logic [7:0]  din_i,
  output logic [63:0] operands_o,
  output logic        pe_start_o,
  input  logic        pe_done_i,
  output logic        mm3_start_o,
  input  logic        mm3_done_i,
  output logic        mm2_start_o,
  input  logic        mm2_done_i,
  output logic        run_display_o,
  input  logic [2:0]  display_state_i,
  output logic [2:0]  state_o,
  output logic        busy_o,
  output logic        done_o,
  output logic        error_o
);

  localparam int unsigned CW        = $clog2(TIMEOUT + 1);
  localparam logic [2:0]  DISP_DONE = 3'd4;

  typedef enum logic [2:0] {
    S_IDLE    = 3'd0,
    S_LOAD    = 3'd1,
    S_PE      = 3'd2,
    S_3X3     = 3'd3,
    S_2X2     = 3'd4,
    S_DISPLAY = 3'd5,
    S_DONE    = 3'd6,
    S_ERROR   = 3'd7
  } state_t;

  state_t          r_state;
  state_t          w_next;
  logic [CW-1:0]   r_cnt;
  logic [2:0]      r_bcnt;
  logic [63:0]     r_operands;
  logic            w_first;
  logic            w_timeout;
  logic            w_run;

  // Phase counter is zero only in the first cycle of a state, so it doubles as the start-pulse qualifier.
  assign w_first   = (r_cnt == '0);
  assign w_timeout = (r_cnt == CW'(TIMEOUT - 1));
  assign w_run     = (r_state == S_PE) || (r_state == S_3X3) ||
                     (r_state == S_2X2) || (r_state == S_DISPLAY);

  // Next-state decode; a qualifying done is checked before the timeout so done wins a tie.
  always_comb begin
    w_next = r_state;
    case (r_state)
      S_IDLE, S_DONE: if (start_i) w_next = S_LOAD;
      S_LOAD:         if (din_valid_i && (r_bcnt == 3'd7)) w_next = S_PE;
      S_PE: begin
        if (!w_first && pe_done_i) w_next = S_3X3;
        else if (w_timeout)        w_next = S_ERROR;
      end
      S_3X3: begin
        if (!w_first && mm3_done_i) w_next = S_2X2;
        else if (w_timeout)         w_next = S_ERROR;
      end
      S_2X2: begin
        if (!w_first && mm2_done_i) w_next = S_DISPLAY;
        else if (w_timeout)         w_next = S_ERROR;
      end
      S_DISPLAY: begin
        if (!w_first && (display_state_i == DISP_DONE)) w_next = S_DONE;
        else if (w_timeout)                              w_next = S_ERROR;
      end
      S_ERROR: w_next = S_ERROR;
      default: w_next = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      r_state    <= S_IDLE;
      r_cnt      <= '0;
      r_bcnt     <= '0;
      r_operands <= '0;
    end else begin
      r_state <= w_next;
      if (w_next != r_state) r_cnt <= '0;
      else if (w_run)        r_cnt <= r_cnt + CW'(1);
      // Byte index wraps to zero after the eighth capture, ready for the next round.
      if (r_state == S_LOAD) begin
        if (din_valid_i) begin
          r_operands[{r_bcnt, 3'b000} +: 8] <= din_i;
          r_bcnt                            <= r_bcnt + 3'd1;
        end
      end else begin
        r_bcnt <= '0;
      end
    end
  end

  assign operands_o    = r_operands;
  assign state_o       = r_state;
  assign pe_start_o    = (r_state == S_PE)  && w_first;
  assign mm3_start_o   = (r_state == S_3X3) && w_first;
  assign mm2_start_o   = (r_state == S_2X2) && w_first;
  assign run_display_o = (r_state == S_DISPLAY);
  assign busy_o        = w_run || (r_state == S_LOAD);
  assign done_o        = (r_state == S_DONE);
  assign error_o       = (r_state == S_ERROR);

endmodule
